// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus write/acknowledge sequencer feeding the UART transmitter.
// Writes are retried on a missing busy acknowledge; queued bytes are never lost.
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle transmitter
// ISSUE | Tx_WR high for exactly one cycle
// ACK   | waiting for Tx_BUSY to rise; timer counts toward a re-issue
// DRAIN | transmitter busy with the byte; waiting for Tx_BUSY to fall
// GAP   | idle spacing before the next write
module uart_tx_feeder #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clear_ovf,
  input  logic          Tx_BUSY,
  output logic [7:0]    Tx_DATA,
  output logic          Tx_WR,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          tx_timeout
);

  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, DRAIN, GAP} state_t;

  state_t         state, state_nxt;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [TW-1:0]  timer, timer_nxt;
  logic           push, pop, load, tx_wr_nxt, timeout_nxt;

  assign fifo_full  = (fifo_count == (AW+1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  // Full is judged on the registered count, so a pop in the same cycle does not admit a push.
  assign push       = wr_en && !fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty && !Tx_BUSY) state_nxt = ISSUE;
      ISSUE:   state_nxt = ACK;
      ACK: begin
        if (Tx_BUSY)          state_nxt = DRAIN;
        else if (timer == '0) state_nxt = ISSUE;
      end
      DRAIN:   if (!Tx_BUSY) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (timer == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load        = 1'b0;
    tx_wr_nxt   = 1'b0;
    pop         = 1'b0;
    timeout_nxt = 1'b0;
    timer_nxt   = timer;
    case (state)
      IDLE: if (!fifo_empty && !Tx_BUSY) begin
        load      = 1'b1;
        tx_wr_nxt = 1'b1;
      end
      ISSUE: timer_nxt = ACK_LOAD;
      ACK: begin
        if (Tx_BUSY) pop = 1'b1;
        else if (timer == '0) begin
          timeout_nxt = 1'b1;
          tx_wr_nxt   = 1'b1;
        end else timer_nxt = timer - 1'b1;
      end
      DRAIN: if (!Tx_BUSY) timer_nxt = GAP_LOAD;
      GAP:   if (timer != '0) timer_nxt = timer - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      Tx_DATA    <= 8'h00;
      Tx_WR      <= 1'b0;
      tx_timeout <= 1'b0;
      timer      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (clear_ovf)     overflow <= 1'b0;
      if (load) Tx_DATA <= mem[rd_ptr];
      Tx_WR      <= tx_wr_nxt;
      tx_timeout <= timeout_nxt;
      timer      <= timer_nxt;
    end
  end

endmodule
